// File: rtl/hdmi_pkg.sv
// -----------------------------------------------------------------------------
// hdmi_pkg
// Shared definitions for the HDMI link supervisor: FSM state encoding (also
// exported on the debug/LED state port) and default timing constants.
// -----------------------------------------------------------------------------
package hdmi_pkg;

   localparam int unsigned STATE_W = 3;

   // Encoding is visible on the state port, keep values stable.
   typedef enum logic [STATE_W-1:0] {
      RESET_HOLD = 3'd0,
      SETTLE     = 3'd1,
      ACQUIRE    = 3'd2,
      STEP       = 3'd3,
      LOCKED     = 3'd4
   } state_e;

   localparam int unsigned DEF_LOCK_CYCLES      = 4096;
   localparam int unsigned DEF_UNLOCK_THRESHOLD = 1048576;
   localparam int unsigned DEF_RESET_CYCLES     = 256;
   localparam int unsigned DEF_SETTLE_CYCLES    = 1024;
   localparam int unsigned DEF_ACQUIRE_TIMEOUT  = 65536;
   localparam int unsigned DEF_NUM_PHASES       = 32;
   localparam int unsigned DEF_RETRY_W          = 8;

endpackage

// File: rtl/hdmi_link_supervisor_sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
// Two-flop synchroniser for a level crossing into the clk domain, with an
// optional rising-edge strobe derived from the synchronised level.
//   clk, reset : system clock, synchronous active-high reset
//   i_d        : asynchronous input level
//   o_q        : synchronised level (registered)
//   o_rise_c   : one-cycle rising-edge strobe (combinational from flops)
// -----------------------------------------------------------------------------
module sync_edge #(
   parameter bit EDGE_EN = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic i_d,
   output logic o_q,
   output logic o_rise_c
);

   logic r_meta;
   logic r_sync;

   // Synchroniser chain.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

   generate
      if (EDGE_EN) begin : g_edge
         logic r_prev;

         // Previous synchronised level for edge detection.
         always_ff @(posedge clk) begin
            if (reset) begin
               r_prev <= 1'b0;
            end else begin
               r_prev <= r_sync;
            end
         end

         assign o_rise_c = r_sync & ~r_prev;
      end else begin : g_no_edge
         assign o_rise_c = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/hdmi_link_supervisor.sv
// -----------------------------------------------------------------------------
// hdmi_link_supervisor
// Supervises the TMDS decoder link: holds decoder reset, waits for settling,
// acquires lock on a run of valid cycles, sweeps the TMDS phase on timeout and
// drops lock through a leaky bucket of invalid cycles. Manual/user overrides.
//   clk, reset        : system clock, synchronous active-high reset
//   hdmi_valid        : decoder valid (asynchronous, synchronised here)
//   user_reset        : level request from display logic
//   manual_reset      : level, active-high
//   manual_phase_step : level, active-high, rising edge requests a step
//   hdmi_reset        : decoder reset, high only in RESET_HOLD
//   phase_step        : one-cycle pulse to the decoder phase input
//   locked            : high only in LOCKED
//   phase_index       : current phase position
//   retry_count       : completed full sweeps, saturating
//   state             : encoded FSM state for debug/LED
// -----------------------------------------------------------------------------
module hdmi_link_supervisor
   import hdmi_pkg::*;
#(
   parameter int unsigned LOCK_CYCLES      = DEF_LOCK_CYCLES,
   parameter int unsigned UNLOCK_THRESHOLD = DEF_UNLOCK_THRESHOLD,
   parameter int unsigned RESET_CYCLES     = DEF_RESET_CYCLES,
   parameter int unsigned SETTLE_CYCLES    = DEF_SETTLE_CYCLES,
   parameter int unsigned ACQUIRE_TIMEOUT  = DEF_ACQUIRE_TIMEOUT,
   parameter int unsigned NUM_PHASES       = DEF_NUM_PHASES,
   parameter int unsigned RETRY_W          = DEF_RETRY_W
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          hdmi_valid,
   input  logic                          user_reset,
   input  logic                          manual_reset,
   input  logic                          manual_phase_step,
   output logic                          hdmi_reset,
   output logic                          phase_step,
   output logic                          locked,
   output logic [$clog2(NUM_PHASES)-1:0] phase_index,
   output logic [RETRY_W-1:0]            retry_count,
   output logic [STATE_W-1:0]            state
);

   localparam int unsigned PW = $clog2(NUM_PHASES);
   localparam int unsigned HW = $clog2(RESET_CYCLES + 1);
   localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
   localparam int unsigned RW = $clog2(LOCK_CYCLES + 1);
   localparam int unsigned TW = $clog2(ACQUIRE_TIMEOUT + 1);
   localparam int unsigned BW = $clog2(UNLOCK_THRESHOLD + 1);

   localparam logic [PW-1:0] IDX_LAST    = PW'(NUM_PHASES - 1);
   localparam logic [HW-1:0] HOLD_LAST   = HW'(RESET_CYCLES - 1);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
   localparam logic [RW-1:0] RUN_END     = RW'(LOCK_CYCLES);
   localparam logic [TW-1:0] TO_END      = TW'(ACQUIRE_TIMEOUT);
   localparam logic [BW-1:0] BKT_END     = BW'(UNLOCK_THRESHOLD);

   state_e               r_state;
   state_e               w_next;
   logic                 w_manual_take;

   logic [HW-1:0]        r_hold_cnt;
   logic [SW-1:0]        r_settle_cnt;
   logic [RW-1:0]        r_run;
   logic [TW-1:0]        r_to;
   logic [BW-1:0]        r_bkt;
   logic [PW-1:0]        r_phase_idx;
   logic [RETRY_W-1:0]   r_retry;
   logic                 r_manual;
   logic                 r_hdmi_reset;
   logic                 r_phase_step;
   logic                 r_locked;

   logic                 w_valid;
   logic                 w_mstep;
   logic                 w_ovr;
   logic                 w_valid_rise_unused;
   logic                 w_mstep_level_unused;
   logic [RW-1:0]        w_run_nxt;
   logic [TW-1:0]        w_to_nxt;
   logic [BW-1:0]        w_bkt_nxt;
   logic [PW-1:0]        w_idx_inc;
   logic                 w_wrap;

   sync_edge #(.EDGE_EN(1'b0)) u_sync_valid (
      .clk      (clk),
      .reset    (reset),
      .i_d      (hdmi_valid),
      .o_q      (w_valid),
      .o_rise_c (w_valid_rise_unused)
   );

   sync_edge #(.EDGE_EN(1'b1)) u_sync_mstep (
      .clk      (clk),
      .reset    (reset),
      .i_d      (manual_phase_step),
      .o_q      (w_mstep_level_unused),
      .o_rise_c (w_mstep)
   );

   assign w_ovr = user_reset | manual_reset;

   // Saturating next values of the counters; each stops at its terminal value.
   assign w_run_nxt = ~w_valid ? '0 : ((r_run == RUN_END) ? r_run : r_run + 1'b1);
   assign w_to_nxt  = (r_to == TO_END) ? r_to : r_to + 1'b1;
   assign w_bkt_nxt = ~w_valid ? ((r_bkt == BKT_END) ? r_bkt : r_bkt + 1'b1)
                               : ((r_bkt == '0) ? r_bkt : r_bkt - 1'b1);
   assign w_idx_inc = (r_phase_idx == IDX_LAST) ? '0 : r_phase_idx + 1'b1;

   // A sweep wraps only on an automatic step landing back on phase 0.
   assign w_wrap = (r_state == STEP) && (w_idx_inc == '0) && ~r_manual;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= RESET_HOLD;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic; overrides applied last so they take priority.
   always_comb begin
      w_next        = r_state;
      w_manual_take = 1'b0;
      case (r_state)
         RESET_HOLD: if (r_hold_cnt == HOLD_LAST)   w_next = SETTLE;
         SETTLE:     if (r_settle_cnt == SETTLE_LAST) w_next = ACQUIRE;
         ACQUIRE: begin
            if (w_run_nxt == RUN_END) begin
               w_next = LOCKED;
            end else if (w_to_nxt == TO_END) begin
               w_next = STEP;
            end
         end
         STEP:       w_next = w_wrap ? RESET_HOLD : SETTLE;
         LOCKED:     if (w_bkt_nxt == BKT_END) w_next = RESET_HOLD;
         default:    w_next = RESET_HOLD;
      endcase
      if (w_mstep && (r_state != RESET_HOLD)) begin
         w_next        = STEP;
         w_manual_take = 1'b1;
      end
      if (w_ovr) begin
         w_next        = RESET_HOLD;
         w_manual_take = 1'b0;
      end
   end

   // Counters, phase/retry tracking and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_hold_cnt   <= '0;
         r_settle_cnt <= '0;
         r_run        <= '0;
         r_to         <= '0;
         r_bkt        <= '0;
         r_phase_idx  <= '0;
         r_retry      <= '0;
         r_manual     <= 1'b0;
         r_hdmi_reset <= 1'b1;
         r_phase_step <= 1'b0;
         r_locked     <= 1'b0;
      end else begin
         // Each counter runs only while its state persists; entry clears it.
         r_hold_cnt   <= (r_state == RESET_HOLD && w_next == RESET_HOLD && !w_ovr)
                         ? r_hold_cnt + 1'b1 : '0;
         r_settle_cnt <= (r_state == SETTLE && w_next == SETTLE)
                         ? r_settle_cnt + 1'b1 : '0;
         r_run        <= (r_state == ACQUIRE && w_next == ACQUIRE) ? w_run_nxt : '0;
         r_to         <= (r_state == ACQUIRE && w_next == ACQUIRE) ? w_to_nxt  : '0;
         r_bkt        <= (r_state == LOCKED && w_next == LOCKED)   ? w_bkt_nxt : '0;

         // The pulse has already gone out during STEP, so the index follows.
         if (r_state == STEP) begin
            r_phase_idx <= w_idx_inc;
         end
         if (w_wrap && !(&r_retry)) begin
            r_retry <= r_retry + 1'b1;
         end
         if (w_next == STEP) begin
            r_manual <= w_manual_take;
         end

         r_hdmi_reset <= (w_next == RESET_HOLD);
         r_phase_step <= (w_next == STEP);
         r_locked     <= (w_next == LOCKED);
      end
   end

   assign hdmi_reset  = r_hdmi_reset;
   assign phase_step  = r_phase_step;
   assign locked      = r_locked;
   assign phase_index = r_phase_idx;
   assign retry_count = r_retry;
   assign state       = r_state;

endmodule

// File: tb/tb_hdmi_link_supervisor.sv
// -----------------------------------------------------------------------------
// tb_hdmi_link_supervisor
// Directed bench for hdmi_link_supervisor with small timing parameters.
// Expected phase_step events are queued ahead of the stimulus and checked
// against the DUT as pulses appear.
// -----------------------------------------------------------------------------
module tb_hdmi_link_supervisor;

   localparam int unsigned NP = 4;
   localparam int unsigned RW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          hdmi_valid = 1'b1;
   logic          user_reset = 1'b0;
   logic          manual_reset = 1'b0;
   logic          manual_phase_step = 1'b0;
   logic          hdmi_reset;
   logic          phase_step;
   logic          locked;
   logic [1:0]    phase_index;
   logic [RW-1:0] retry_count;
   logic [2:0]    state;

   hdmi_link_supervisor #(
      .LOCK_CYCLES      (8),
      .UNLOCK_THRESHOLD (16),
      .RESET_CYCLES     (4),
      .SETTLE_CYCLES    (4),
      .ACQUIRE_TIMEOUT  (32),
      .NUM_PHASES       (NP),
      .RETRY_W          (RW)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .hdmi_valid        (hdmi_valid),
      .user_reset        (user_reset),
      .manual_reset      (manual_reset),
      .manual_phase_step (manual_phase_step),
      .hdmi_reset        (hdmi_reset),
      .phase_step        (phase_step),
      .locked            (locked),
      .phase_index       (phase_index),
      .retry_count       (retry_count),
      .state             (state)
   );

   always #5 clk = ~clk;

   int          vectors = 0;
   int          miscompares = 0;
   int          steps_seen = 0;
   logic        prev_ps = 1'b0;
   logic [31:0] sb[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Expected {retry_count, phase_index} while a phase_step pulse is high.
   function automatic logic [31:0] pos(input int r, input int i);
      return 32'((r * NP) + i);
   endfunction

   // Advance one clock, sample #1 later and score any phase_step pulse.
   task automatic tick();
      logic [31:0] e;
      @(posedge clk);
      #1;
      if (prev_ps) chk("pulse_width", 32'(phase_step), 32'd0);
      if (phase_step) begin
         steps_seen++;
         if (sb.size() == 0) begin
            chk("unexpected_step", 32'(phase_step), 32'd0);
         end else begin
            e = sb.pop_front();
            chk("step_pos", 32'({retry_count, phase_index}), e);
         end
      end
      prev_ps = phase_step;
   endtask

   function automatic logic sig(input int sel);
      case (sel)
         0:       return hdmi_reset;
         1:       return locked;
         2:       return (state == 3'd2);
         default: return phase_step;
      endcase
   endfunction

   // Ticks until the selected condition equals lvl; n = budget on expiry.
   task automatic wait_sig(input int sel, input logic lvl, input int budget, output int n);
      n = 0;
      while ((sig(sel) !== lvl) && (n < budget)) begin
         tick();
         n++;
      end
   endtask

   task automatic wait_steps(input int target, input int budget, input string tag);
      int n;
      n = 0;
      while ((steps_seen < target) && (n < budget)) begin
         tick();
         n++;
      end
      if (steps_seen < target) chk(tag, 32'(steps_seen), 32'(target));
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_state"},  32'(state),       32'd0);
      chk({tag, "_hrst"},   32'(hdmi_reset),  32'd1);
      chk({tag, "_pstep"},  32'(phase_step),  32'd0);
      chk({tag, "_locked"}, 32'(locked),      32'd0);
      chk({tag, "_idx"},    32'(phase_index), 32'd0);
      chk({tag, "_retry"},  32'(retry_count), 32'd0);
   endtask

   initial begin
      int n;
      int bad;
      int tgt;
      int i;

      // Reset state, then release with valid held high.
      tick();
      tick();
      check_reset_vals("por");
      reset = 1'b0;
      wait_sig(0, 1'b0, 20, n);
      chk("hold_len", 32'(n), 32'd4);
      chk("settle_entry", 32'(state), 32'd1);
      wait_sig(2, 1'b1, 20, n);
      chk("settle_len", 32'(n), 32'd4);
      wait_sig(1, 1'b1, 40, n);
      chk("lock_len", 32'(n), 32'd8);
      chk("lock_state", 32'(state), 32'd4);
      chk("lock_idx", 32'(phase_index), 32'd0);

      // Alternating valid keeps lock; solid invalid drains the bucket.
      bad = 0;
      for (int k = 0; k < 1000; k++) begin
         hdmi_valid = k[0];
         tick();
         if (locked !== 1'b1) bad++;
      end
      chk("alt_keeps_lock", 32'(bad), 32'd0);
      hdmi_valid = 1'b0;
      wait_sig(0, 1'b1, 40, n);
      chk("unlock_len", 32'(n), 32'd18);
      chk("unlock_locked", 32'(locked), 32'd0);
      chk("unlock_idx", 32'(phase_index), 32'd0);

      // Invalid forever: full sweeps until retry_count saturates.
      for (int s = 0; s < 256; s++) begin
         for (int p = 0; p < int'(NP); p++) sb.push_back(pos((s > 255) ? 255 : s, p));
         tgt = steps_seen + int'(NP);
         wait_steps(tgt, 300, "sweep_timeout");
         tick();
         chk("wrap_hrst", 32'(hdmi_reset), 32'd1);
         chk("wrap_idx", 32'(phase_index), 32'd0);
         chk("wrap_retry", 32'(retry_count), 32'((s + 1 > 255) ? 255 : s + 1));
      end

      // 7 valid / 1 invalid never locks and times out into a step.
      sb.push_back(pos(255, 0));
      tgt = steps_seen + 1;
      bad = 0;
      i = 0;
      while ((steps_seen < tgt) && (i < 400)) begin
         hdmi_valid = ((i % 8) != 7);
         tick();
         if (locked) bad++;
         i++;
      end
      chk("pattern_no_lock", 32'(bad), 32'd0);
      if (steps_seen < tgt) chk("pattern_step", 32'(steps_seen), 32'(tgt));
      hdmi_valid = 1'b1;
      wait_sig(1, 1'b1, 60, n);
      chk("relock_len", 32'(n), 32'd13);
      chk("relock_idx", 32'(phase_index), 32'd1);

      // Manual reset held 10 cycles while locked.
      manual_reset = 1'b1;
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (hdmi_reset) bad++;
      end
      chk("mrst_high", 32'(bad), 32'd10);
      manual_reset = 1'b0;
      wait_sig(0, 1'b0, 20, n);
      chk("mrst_tail", 32'(n), 32'd4);
      chk("mrst_idx", 32'(phase_index), 32'd1);
      chk("mrst_retry", 32'(retry_count), 32'd255);
      wait_sig(1, 1'b1, 40, n);
      chk("mrst_relock", 32'(n), 32'd12);

      // Manual phase step while locked.
      sb.push_back(pos(255, 1));
      manual_phase_step = 1'b1;
      tgt = steps_seen + 1;
      n = 0;
      while ((steps_seen < tgt) && (n < 10)) begin
         tick();
         n++;
      end
      chk("mstep_lat", 32'(n), 32'd3);
      tick();
      chk("mstep_state", 32'(state), 32'd1);
      chk("mstep_idx", 32'(phase_index), 32'd2);
      chk("mstep_retry", 32'(retry_count), 32'd255);
      manual_phase_step = 1'b0;
      wait_sig(1, 1'b1, 40, n);
      chk("mstep_relock", 32'(n), 32'd12);

      // Reset mid-LOCKED.
      reset = 1'b1;
      tick();
      check_reset_vals("rst_locked");
      reset = 1'b0;

      // Reset mid-STEP.
      hdmi_valid = 1'b0;
      sb.push_back(pos(0, 0));
      wait_steps(steps_seen + 1, 100, "rst_step_timeout");
      reset = 1'b1;
      tick();
      check_reset_vals("rst_step");
      reset = 1'b0;
      tick();
      tick();

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/hdmi_link_supervisor.md
Name: hdmi_link_supervisor

Overview:
- Successor to the fixed 21-bit invalid-counter watchdog that drives the TMDS decoder reset.
- Adds parametrised lock/unlock hysteresis, an automatic TMDS phase sweep through the decoder's phase_step input, and manual overrides.
- Reports status: locked, phase index and retry count.
- Sits between tmds_decoder and the display module, in the clk (system) domain.

Parameters:
- LOCK_CYCLES, 4096, consecutive synced-valid cycles needed to declare lock.
- UNLOCK_THRESHOLD, 1048576, leaky-bucket level that declares loss of lock.
- RESET_CYCLES, 256, cycles hdmi_reset is held per reset event.
- SETTLE_CYCLES, 1024, wait after reset release or after a phase step.
- ACQUIRE_TIMEOUT, 65536, ACQUIRE cycles allowed before stepping phase.
- NUM_PHASES, 32, phase positions per sweep (≥2).
- RETRY_W, 8, width of retry_count.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high
- hdmi_valid  input  1  decoder valid, asynchronous to clk
- user_reset  input  1  level request from display logic
- manual_reset  input  1  level, active-high (already inverted switch)
- manual_phase_step  input  1  level, active-high (already inverted switch)
- hdmi_reset  output  1  decoder reset
- phase_step  output  1  one-cycle pulse to decoder
- locked  output  1  link locked
- phase_index  output  $clog2(NUM_PHASES)  current phase position
- retry_count  output  RETRY_W  completed full sweeps, saturating
- state  output  3  encoded FSM state, for debug/LED

Behaviour:
- Synchronisation: hdmi_valid passes a 2-flop synchroniser; "v" below means the synchronised value. manual_phase_step is synchronised and rising-edge detected.
- Reset (reset=1) sets:
  - state=RESET_HOLD, hdmi_reset=1, phase_step=0, locked=0;
  - phase_index=0, retry_count=0, all counters 0.
- Outputs are registered. hdmi_reset=1 only in RESET_HOLD; locked=1 only in LOCKED.
- RESET_HOLD:
  - timer counts 0..RESET_CYCLES-1, then go to SETTLE, so hdmi_reset is high for exactly RESET_CYCLES cycles.
  - While user_reset or manual_reset is high, the timer is held at 0.
- SETTLE: wait SETTLE_CYCLES, then go to ACQUIRE; clear run counter and timeout timer.
- ACQUIRE:
  - v=1 increments the run counter; v=0 clears it.
  - run counter reaching LOCK_CYCLES → LOCKED; clear the bucket.
  - Otherwise, timeout reaching ACQUIRE_TIMEOUT → STEP.
  - If both conditions hit in the same cycle, lock wins.
- STEP (one cycle):
  - phase_step=1 on the next cycle; phase_index increments modulo NUM_PHASES.
  - If the new index is 0 (sweep wrapped): retry_count increments (saturating at all-ones), go to RESET_HOLD.
  - Otherwise go to SETTLE.
- LOCKED, leaky bucket:
  - v=0 → bucket+1; v=1 → bucket-1, floor 0.
  - Bucket reaching UNLOCK_THRESHOLD → RESET_HOLD; phase_index is kept.
  - Isolated invalid cycles therefore never unlock.
- Overrides, highest priority first:
  1. reset
  2. user_reset or manual_reset high in any state → RESET_HOLD next cycle; phase_index and retry_count are kept.
  3. manual_phase_step rising edge in any state except RESET_HOLD → STEP behaviour, always followed by SETTLE (no retry increment, even on wrap).
- Counter widths are $clog2(param+1). There is no overflow; each counter stops at its terminal value.

Decomposition:
- Shared package hdmi_pkg holds:
  - state encoding constants: RESET_HOLD=0, SETTLE=1, ACQUIRE=2, STEP=3, LOCKED=4;
  - default timing constants.
- One natural sub-module: sync_edge, a 2-flop synchroniser with optional rising-edge output, instantiated for hdmi_valid and manual_phase_step.

Test Plan:
- All scenarios use LOCK=8, UNLOCK=16, RESET=4, SETTLE=4, TIMEOUT=32, NUM_PHASES=4.
- Reset release with hdmi_valid=1 constant → hdmi_reset high exactly 4 cycles, then 4 SETTLE cycles; locked=1 after 8 valid cycles plus 2 sync cycles; phase_index=0.
- Locked, then alternating valid/invalid for 1000 cycles → locked stays 1. Then invalid held → locked=0 and hdmi_reset=1 16 cycles (+2 sync) after bucket start.
- hdmi_valid=0 forever → phase_step pulses (one cycle each) with phase_index 1,2,3; fourth step wraps to 0, retry_count=1, hdmi_reset reasserted; repeat until retry_count saturates at 255.
- hdmi_valid toggling 7 valid / 1 invalid in ACQUIRE → never locks, steps after timeout; then valid held → locks at the current phase_index.
- manual_reset held 10 cycles while LOCKED → hdmi_reset high 10+4 cycles; phase_index unchanged. manual_phase_step edge while LOCKED → single phase_step pulse, index+1, state SETTLE.
- reset asserted mid-STEP and mid-LOCKED → next cycle all outputs at reset values, including retry_count=0.
